booth_multiplier: RTL and testbench
===================================

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; accepted only in IDLE.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled on accept.
REQ-006 The block SHALL have port multiplicand, input, WIDTH bits: operand M, sampled on accept.
REQ-007 The block SHALL have port multiplier, input, WIDTH bits: operand Q, sampled on accept.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when product becomes valid.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: registered result.

Function
REQ-011 Internal operands SHALL be extended to WIDTH+1 bits: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-012 Datapath SHALL hold accumulator A (WIDTH+1 bits), multiplier register Q (WIDTH+1 bits), flop Qm1 (1 bit), multiplicand register M (WIDTH+1 bits), iteration counter CNT ($clog2(WIDTH+2) bits).
REQ-013 FSM states SHALL be IDLE, EVAL, SHIFT, DONE.
REQ-014 In IDLE with start=1: same edge loads M, Q, A=0, Qm1=0, CNT=WIDTH+1; next state EVAL.
REQ-015 In IDLE with start=0: stay IDLE; all registers hold.
REQ-016 EVAL: {Q[0],Qm1}=10 gives A=A-M; 01 gives A=A+M; 00 or 11 leaves A unchanged; CNT decremented; next state SHIFT.
REQ-017 Add/subtract SHALL be modulo 2^(WIDTH+1), with no overflow flag.
REQ-018 SHIFT: {A,Q,Qm1} arithmetic-shifted right by one, with A MSB replicated; next state EVAL if CNT!=0, else DONE.
REQ-019 DONE: product loaded from the lower 2*WIDTH bits of {A,Q}; done=1 for this cycle only; next state IDLE.
REQ-020 Latency SHALL be fixed: done is high exactly 2*WIDTH+3 cycles after the accepting edge (19 for WIDTH=8), independent of operand values.
REQ-021 start while busy=1 SHALL be ignored, with no queuing and no effect on the in-flight operation.
REQ-022 start held high continuously SHALL start a new operation on the edge following the DONE cycle, i.e. on the first IDLE cycle.
REQ-023 product SHALL hold its value from DONE until the next DONE and SHALL NOT change during an operation.
REQ-024 Operand and signed_mode changes after accept SHALL NOT affect the result.
REQ-025 Boundary operands SHALL give exact results: signed most-negative × most-negative, unsigned all-ones × all-ones, and zero operands.

Reset
REQ-026 While rst=1 on a clock edge: state=IDLE, A=0, Q=0, M=0, Qm1=0, CNT=0, product=0, busy=0, done=0.
REQ-027 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL NOT assert done.
REQ-028 On the first edge with rst=0 and start=1, the block SHALL accept normally.

Structure
REQ-029 A shared package booth_pkg SHALL hold the FSM state enum (IDLE, EVAL, SHIFT, DONE) and the Booth decode constants (OP_NOP, OP_ADD, OP_SUB).
REQ-030 The FSM SHALL be a sub-module booth_ctrl (inputs q0, qm1, cnt_zero, start; outputs load, add, sub, shift, dec, done, busy), with the datapath in booth_multiplier.
REQ-031 Next-state and output logic SHALL be fully specified in every state (no latches); unreachable encodings SHALL return to IDLE.

Verification (WIDTH=8)
REQ-032 signed_mode=1, M=7, Q=-3 (8'hFD) -> product=16'hFFEB, done at cycle 19 after accept.
REQ-033 signed_mode=1, M=8'h80, Q=8'h80 -> product=16'h4000; signed_mode=1, M=8'h80, Q=8'h7F -> product=16'hC080.
REQ-034 signed_mode=0, M=8'hFF, Q=8'hFF -> product=16'hFE01; signed_mode=0, M=0, Q=8'hA5 -> product=16'h0000.
REQ-035 Accept 3×5, then pulse start with operands 9×9 at cycle 5 -> second request ignored, product=16'h000F, exactly one done pulse.
REQ-036 rst asserted at cycle 10 of an operation -> busy=0 and product=0 on the next cycle, no done; a following 2×3 gives 16'h0006 at cycle 19.
REQ-037 Random signed and unsigned operand pairs (≥1000 of each) compared against a reference product -> all match, busy high for exactly 19 cycles per operation.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states and Booth
// recoding of the {Q[0], Qm1} bit pair.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Sequencer for the Booth multiplier: alternates EVAL/SHIFT until the
// iteration counter drains, then spends one cycle in DONE.
module booth_ctrl
  import booth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic cnt_zero,
  output logic load,
  output logic add,
  output logic sub,
  output logic shift,
  output logic dec,
  output logic done,
  output logic busy
);

  state_t state, state_nxt;
  logic [1:0] op;

  assign op = booth_decode(q0, qm1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? EVAL : IDLE;
      EVAL:    state_nxt = SHIFT;
      SHIFT:   state_nxt = cnt_zero ? DONE : EVAL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    sub   = 1'b0;
    shift = 1'b0;
    dec   = 1'b0;
    done  = 1'b0;
    busy  = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        load = start;
      end
      EVAL: begin
        add = (op == OP_ADD);
        sub = (op == OP_SUB);
        dec = 1'b1;
      end
      SHIFT:   shift = 1'b1;
      DONE:    done  = 1'b1;
      default: busy  = 1'b0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier over WIDTH+1-bit extended operands,
// covering both signed and unsigned products with one datapath.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  logic signed [WIDTH:0] a, m;
  logic        [WIDTH:0] q;
  logic                  qm1;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_zero;
  logic load, add, sub, shift, dec;
  logic [2*WIDTH-1:0]    shifted_aq;

  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] x, input logic sm);
    return {sm & x[WIDTH-1], x};
  endfunction

  assign cnt_zero = (cnt == '0);

  // Low 2*WIDTH bits of {A,Q} after the pending shift, captured on the final
  // shift so that product is already valid while done is high.
  assign shifted_aq = {a[WIDTH-1:0], q[WIDTH:1]};

  booth_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q0       (q[0]),
    .qm1      (qm1),
    .cnt_zero (cnt_zero),
    .load     (load),
    .add      (add),
    .sub      (sub),
    .shift    (shift),
    .dec      (dec),
    .done     (done),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (load) begin
        m   <= extend(multiplicand, signed_mode);
        q   <= extend(multiplier, signed_mode);
        a   <= '0;
        qm1 <= 1'b0;
        cnt <= CNT_W'(WIDTH + 1);
      end
      if (add) a <= a + m;
      if (sub) a <= a - m;
      if (dec) cnt <= cnt - 1'b1;
      if (shift) begin
        a   <= {a[WIDTH], a[WIDTH:1]};
        q   <= {a[0], q[WIDTH:1]};
        qm1 <= q[0];
        if (cnt_zero) product <= shifted_aq;
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and random checks of booth_multiplier at WIDTH=8.
module tb_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int tests = 0;
  int fails = 0;

  booth_multiplier #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       sm;
    logic [7:0] mc;
    logic [7:0] mp;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one multiply, scrambles the inputs after accept, and observes the
  // operation cycle by cycle (cycle 1 = first cycle after the accepting edge).
  task automatic run_op(input logic sm, input logic [7:0] mc, input logic [7:0] mp,
                        output logic [15:0] prod, output int done_cyc,
                        output int busy_cnt, output int done_cnt, output bit hold_ok);
    logic [15:0] prev;
    prod = 'x; done_cyc = 0; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
    @(negedge clk);
    signed_mode = sm; multiplicand = mc; multiplier = mp; start = 1'b1;
    prev = product;
    tick();
    start = 1'b0;
    signed_mode = ~sm;
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    for (int c = 1; c <= 30; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          prod = product;
        end
      end else if (done_cnt == 0 && product !== prev) begin
        hold_ok = 1'b0;
      end
      if (done_cnt > 0 && c > done_cyc) break;
      tick();
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic sm, input logic [7:0] mc, input logic [7:0] mp);
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub;
    sa = $signed(mc);
    sb = $signed(mp);
    ua = {8'h00, mc};
    ub = {8'h00, mp};
    return sm ? 16'(sa * sb) : 16'(ua * ub);
  endfunction

  initial begin
    logic [15:0] prod;
    int dcyc, bcnt, dcnt;
    bit hold;
    logic [7:0] ra, rb;

    vecs[0]  = '{"s_7_x_m3",      1'b1, 8'h07, 8'hFD, 16'hFFEB};
    vecs[1]  = '{"s_min_x_min",   1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{"s_min_x_max",   1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[3]  = '{"u_ff_x_ff",     1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4]  = '{"u_0_x_a5",      1'b0, 8'h00, 8'hA5, 16'h0000};
    vecs[5]  = '{"s_m1_x_m1",     1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[6]  = '{"s_max_x_max",   1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[7]  = '{"u_80_x_80",     1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[8]  = '{"u_fd_x_7",      1'b0, 8'hFD, 8'h07, 16'h06EB};
    vecs[9]  = '{"s_1_x_min",     1'b1, 8'h01, 8'h80, 16'hFF80};
    vecs[10] = '{"s_0_x_0",       1'b1, 8'h00, 8'h00, 16'h0000};
    vecs[11] = '{"u_max_x_80",    1'b0, 8'h7F, 8'h80, 16'h3F80};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    // Release reset with start already high: accept on the first free edge.
    @(negedge clk);
    rst = 1'b0; start = 1'b1; signed_mode = 1'b0; multiplicand = 8'd6; multiplier = 8'd7;
    tick();
    start = 1'b0;
    check("accept_after_reset_busy", 32'(busy), 32'd1);
    dcyc = 0;
    for (int c = 1; c <= 30 && dcyc == 0; c++) begin
      if (done) dcyc = c;
      else tick();
    end
    check("accept_after_reset_cycle", 32'(dcyc), 32'd19);
    check("accept_after_reset_product", 32'(product), 32'h002A);
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].sm, vecs[i].mc, vecs[i].mp, prod, dcyc, bcnt, dcnt, hold);
      check({vecs[i].name, "_product"}, 32'(prod), 32'(vecs[i].exp));
      check({vecs[i].name, "_latency"}, 32'(dcyc), 32'd19);
      check({vecs[i].name, "_busy"}, 32'(bcnt), 32'd19);
      check({vecs[i].name, "_ndone"}, 32'(dcnt), 32'd1);
      check({vecs[i].name, "_hold"}, 32'(hold), 32'd1);
    end

    // Start during busy is ignored.
    @(negedge clk);
    signed_mode = 1'b0; multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0; dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin dcnt++; if (dcyc == 0) dcyc = c; end
      if (c == 5) begin start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9; end
      else start = 1'b0;
      tick();
    end
    check("ignore_start_ndone", 32'(dcnt), 32'd1);
    check("ignore_start_cycle", 32'(dcyc), 32'd19);
    check("ignore_start_product", 32'(product), 32'h000F);
    check("ignore_start_idle", 32'(busy), 32'd0);

    // Reset during an operation aborts it without done.
    @(negedge clk);
    signed_mode = 1'b0; multiplicand = 8'd100; multiplier = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 9; c++) begin
      if (done) dcnt++;
      tick();
    end
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    run_op(1'b0, 8'd2, 8'd3, prod, dcyc, bcnt, dcnt, hold);
    check("after_abort_product", 32'(prod), 32'h0006);
    check("after_abort_latency", 32'(dcyc), 32'd19);

    // start held high restarts on the first IDLE cycle after DONE.
    @(negedge clk);
    signed_mode = 1'b0; multiplicand = 8'd4; multiplier = 8'd5; start = 1'b1;
    tick();
    dcyc = 0;
    for (int c = 1; c <= 30 && dcyc == 0; c++) begin
      if (done) dcyc = c;
      else tick();
    end
    check("held_start_first", 32'(product), 32'h0014);
    tick();
    check("held_start_idle_gap", 32'(busy), 32'd0);
    tick();
    check("held_start_restart", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (25) tick();

    for (int k = 0; k < 2000; k++) begin
      logic sm;
      sm = (k < 1000);
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(sm, ra, rb, prod, dcyc, bcnt, dcnt, hold);
      check(sm ? "rand_s_product" : "rand_u_product", 32'(prod), 32'(ref_mul(sm, ra, rb)));
      check(sm ? "rand_s_busy" : "rand_u_busy", 32'(bcnt), 32'd19);
      check(sm ? "rand_s_latency" : "rand_u_latency", 32'(dcyc), 32'd19);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
